// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames raw PS/2 bits, checks parity and stop, and turns make codes into
// one-cycle 4-bit calculator key events with break/extended-prefix and typematic-repeat handling.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic [7:0] scan_byte,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  // bit 0 = ps2_clk, bit 1 = ps2_data; both idle high on the bus.
  logic [1:0] pins;
  logic [1:0] sync_bits;
  assign pins = {ps2_data, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pins[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic clk_s;
  logic data_s;
  logic clk_prev_reg;
  logic fall;
  assign clk_s  = sync_bits[0];
  assign data_s = sync_bits[1];
  assign fall   = clk_prev_reg & ~clk_s;

  state_t           state_reg;
  logic [3:0]       bit_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic             stop_reg;
  logic             brk_reg;
  logic             ext_reg;
  logic             held_valid_reg;
  logic [7:0]       held_code_reg;

  logic       frame_ok;
  logic       map_hit;
  logic [3:0] map_val;
  logic       is_repeat;

  assign frame_ok  = (^{shift_reg, parity_reg}) & stop_reg;
  assign is_repeat = held_valid_reg && (shift_reg == held_code_reg);

  always_comb begin
    map_hit = 1'b1;
    map_val = 4'd0;
    case (shift_reg)
      8'h45, 8'h70: map_val = 4'd0;
      8'h16, 8'h69: map_val = 4'd1;
      8'h1E, 8'h72: map_val = 4'd2;
      8'h26, 8'h7A: map_val = 4'd3;
      8'h25, 8'h6B: map_val = 4'd4;
      8'h2E, 8'h73: map_val = 4'd5;
      8'h36, 8'h74: map_val = 4'd6;
      8'h3D, 8'h6C: map_val = 4'd7;
      8'h3E, 8'h75: map_val = 4'd8;
      8'h46, 8'h7D: map_val = 4'd9;
      8'h79:        map_val = 4'd10;
      8'h4E, 8'h7B: map_val = 4'd11;
      8'h7C:        map_val = 4'd12;
      8'h4A:        map_val = 4'd13;
      8'h5A, 8'h55: map_val = 4'd14;
      8'h76:        map_val = 4'd15;
      default:      map_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg      <= IDLE;
      clk_prev_reg   <= 1'b1;
      bit_cnt_reg    <= 4'd0;
      cnt_reg        <= '0;
      shift_reg      <= 8'h00;
      parity_reg     <= 1'b0;
      stop_reg       <= 1'b0;
      brk_reg        <= 1'b0;
      ext_reg        <= 1'b0;
      held_valid_reg <= 1'b0;
      held_code_reg  <= 8'h00;
      key_value      <= 4'd0;
      key_valid      <= 1'b0;
      scan_byte      <= 8'h00;
      frame_err      <= 1'b0;
    end else begin
      clk_prev_reg <= clk_s;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fall && !data_s) begin
            state_reg   <= RECV;
            bit_cnt_reg <= 4'd0;
            cnt_reg     <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            cnt_reg     <= '0;
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg < 4'd8) begin
              shift_reg <= {data_s, shift_reg[7:1]};
            end else if (bit_cnt_reg == 4'd8) begin
              parity_reg <= data_s;
            end else begin
              stop_reg  <= data_s;
              state_reg <= DONE;
            end
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Device stalled mid-frame: drop the partial byte, prefixes untouched.
            state_reg <= IDLE;
            frame_err <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          if (!frame_ok) begin
            frame_err <= 1'b1;
          end else begin
            scan_byte <= shift_reg;
            if (shift_reg == 8'hF0) begin
              brk_reg <= 1'b1;
            end else if (shift_reg == 8'hE0) begin
              ext_reg <= 1'b1;
            end else begin
              brk_reg <= 1'b0;
              ext_reg <= 1'b0;
              if (brk_reg) begin
                if (is_repeat) held_valid_reg <= 1'b0;
              end else if (map_hit && !is_repeat) begin
                key_value      <= map_val;
                key_valid      <= 1'b1;
                held_code_reg  <= shift_reg;
                held_valid_reg <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
